// File: rtl/multiply_log_rr_sched_if.sv
// multiply_log_rr_sched_if: request, config and result signals of the shared shift multiplier
interface multiply_log_rr_sched_if #(
  parameter int DW     = 25,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int SH_W   = 5
);
  logic [NUM_CH-1:0]    req_en;
  logic [NUM_CH*DW-1:0] req_data;
  logic [NUM_CH-1:0]    req_ack;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [SH_W-1:0]      cfg_shift;
  logic                 data_o_en;
  logic [DW-1:0]        data_o;
  logic [CH_W-1:0]      data_o_ch;
  modport master (
    output req_en, req_data, cfg_we, cfg_ch, cfg_shift,
    input  req_ack, data_o_en, data_o, data_o_ch
  );
  modport slave (
    input  req_en, req_data, cfg_we, cfg_ch, cfg_shift,
    output req_ack, data_o_en, data_o, data_o_ch
  );
endinterface

// File: rtl/multiply_log_rr_sched.sv
// multiply_log_rr_sched: round-robin time-sharing of one signed power-of-two shifter among channels
module multiply_log_rr_sched #(
  parameter int width_H    = 5,
  parameter int width_W    = 20,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int SH_W       = 5,
  parameter int DEFAULT_SH = 0
) (
  input logic clk,
  input logic rst,
  multiply_log_rr_sched_if.slave bus
);
  localparam int DW = width_H + width_W;
  localparam int PW = 2 * DW - 1;
  logic [NUM_CH-1:0] ack_q, ack_d, elig;
  logic [CH_W-1:0] ptr_q, ptr_d, g, idx;
  logic found;
  logic signed [SH_W-1:0] coef_q [NUM_CH];
  logic s1_v_q;
  logic [DW-1:0] s1_data_q;
  logic signed [SH_W-1:0] s1_sh_q;
  logic [CH_W-1:0] s1_ch_q;
  logic en_q;
  logic [DW-1:0] data_q, data_d;
  logic [CH_W-1:0] ch_q;
  logic signed [PW-1:0] ext;
  int mag;
  // the channel acked last cycle may still hold req_en high, so it is masked out
  always_comb begin
    elig = bus.req_en & ~ack_q;
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
    ack_d = found ? NUM_CH'(1) << g : '0;
    ptr_d = found ? ((int'(g) == NUM_CH - 1) ? '0 : g + 1'b1) : ptr_q;
  end
  always_comb begin
    ext = {{(PW-DW){s1_data_q[DW-1]}}, s1_data_q};
    mag = s1_sh_q[SH_W-1] ? -int'(s1_sh_q) : int'(s1_sh_q);
    data_d = s1_sh_q[SH_W-1] ? ((mag >= PW) ? {DW{ext[PW-1]}} : DW'(ext >>> mag))
                             : ((mag >= PW) ? '0 : DW'(ext << mag));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= '0;
      ptr_q <= '0;
      s1_v_q <= 1'b0;
      s1_data_q <= '0;
      s1_sh_q <= '0;
      s1_ch_q <= '0;
      en_q <= 1'b0;
      data_q <= '0;
      ch_q <= '0;
      for (int i = 0; i < NUM_CH; i++) coef_q[i] <= SH_W'(DEFAULT_SH);
    end else begin
      ack_q <= ack_d;
      ptr_q <= ptr_d;
      s1_v_q <= found;
      if (found) begin
        s1_data_q <= bus.req_data[int'(g)*DW +: DW];
        s1_sh_q <= coef_q[g];
        s1_ch_q <= g;
      end
      en_q <= s1_v_q;
      if (s1_v_q) begin
        data_q <= data_d;
        ch_q <= s1_ch_q;
      end
      if (bus.cfg_we && int'(bus.cfg_ch) < NUM_CH) coef_q[bus.cfg_ch] <= bus.cfg_shift;
    end
  end
  assign bus.req_ack = ack_q;
  assign bus.data_o_en = en_q;
  assign bus.data_o = data_q;
  assign bus.data_o_ch = ch_q;
endmodule

// File: tb/tb_multiply_log_rr_sched.sv
// tb_multiply_log_rr_sched: scoreboard bench for the round-robin shift scheduler
module tb_multiply_log_rr_sched;
  localparam int DW = 25;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int SW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  multiply_log_rr_sched_if #(.DW(DW), .NUM_CH(NC), .CH_W(CW), .SH_W(SW)) bus();
  multiply_log_rr_sched dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [DW-1:0] pend [NC][$];
  logic [CW+DW-1:0] sb[$];
  logic [CW+DW-1:0] out_log[$];
  int out_cyc_log[$];
  int ack_log[$];
  logic signed [SW-1:0] coef_m [NC];
  logic [NC-1:0] prev_ack;
  logic [CW+DW-1:0] e;
  int last_ack_cyc = 0;
  int last_out_cyc = 0;

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic signed [SW-1:0] sh);
    longint v;
    int m;
    v = longint'(signed'(d));
    m = sh;
    if (m >= 0) v = (m >= 2*DW-1) ? 64'sd0 : v <<< m;
    else v = (-m >= 2*DW-1) ? ((v < 0) ? -64'sd1 : 64'sd0) : v >>> (-m);
    return v[DW-1:0];
  endfunction

  function automatic bit all_idle();
    bit r;
    r = (sb.size() == 0);
    for (int c = 0; c < NC; c++) if (pend[c].size() != 0) r = 0;
    return r;
  endfunction

  function automatic logic [CW+DW-1:0] last_out();
    return (out_log.size() > 0) ? out_log[out_log.size()-1] : 'x;
  endfunction

  // scoreboard, reference model and requester: all run 1 time unit after each rising edge
  initial begin
    bus.req_en = '0;
    bus.req_data = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_shift = '0;
    prev_ack = '0;
    for (int c = 0; c < NC; c++) coef_m[c] = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.data_o_en === 1'b1) begin
        out_log.push_back({bus.data_o_ch, bus.data_o});
        out_cyc_log.push_back(cyc);
        last_out_cyc = cyc;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h required=none", {bus.data_o_ch, bus.data_o});
        end else begin
          e = sb.pop_front();
          if ({bus.data_o_ch, bus.data_o} !== e) begin
            bad++;
            $display("FAIL sb_result got ch=%0d data=%h required ch=%0d data=%h",
                     bus.data_o_ch, bus.data_o, e[DW+:CW], e[DW-1:0]);
          end
        end
      end
      if (rst) begin
        sb.delete();
        for (int c = 0; c < NC; c++) coef_m[c] = '0;
        prev_ack = '0;
      end else begin
        total++;
        if ((bus.req_ack & (bus.req_ack - 1'b1)) !== '0) begin
          bad++;
          $display("FAIL ack_onehot got=%b required=onehot_or_zero", bus.req_ack);
        end
        total++;
        if ((bus.req_ack & prev_ack) !== '0) begin
          bad++;
          $display("FAIL ack_repeat got=%b prev=%b required=no_overlap", bus.req_ack, prev_ack);
        end
        for (int c = 0; c < NC; c++) begin
          if (bus.req_ack[c] === 1'b1) begin
            ack_log.push_back(c);
            last_ack_cyc = cyc;
            if (pend[c].size() == 0) begin
              bad++;
              $display("FAIL ack_spurious ch=%0d got=ack required=no_ack", c);
            end else begin
              sb.push_back({CW'(c), model(pend[c][0], coef_m[c])});
              void'(pend[c].pop_front());
            end
          end
        end
        if (bus.cfg_we && int'(bus.cfg_ch) < NC) coef_m[bus.cfg_ch] = bus.cfg_shift;
        prev_ack = bus.req_ack;
      end
      for (int c = 0; c < NC; c++) begin
        bus.req_en[c] = (pend[c].size() != 0);
        bus.req_data[c*DW +: DW] = (pend[c].size() != 0) ? pend[c][0] : '0;
      end
    end
  end

  task automatic cfg_write(input int c, input int sh);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = CW'(c);
    bus.cfg_shift = SW'(sh);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (all_idle()) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < NC; c++) pend[c].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.req_ack !== '0) begin bad++; $display("FAIL rst_ack got=%b required=0", bus.req_ack); end
    total++;
    if (bus.data_o_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b required=0", bus.data_o_en); end
    total++;
    if (bus.data_o !== '0) begin bad++; $display("FAIL rst_data got=%h required=0", bus.data_o); end
    total++;
    if (bus.data_o_ch !== '0) begin bad++; $display("FAIL rst_ch got=%0d required=0", bus.data_o_ch); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    out_log.delete();
    pend[0].push_back(25'h0012345);
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout got=busy required=idle"); end
    total++;
    if (last_out() !== {2'd0, 25'h0012345}) begin
      bad++; $display("FAIL single_data got=%h required=%h", last_out(), {2'd0, 25'h0012345});
    end
    total++;
    if (last_out_cyc - last_ack_cyc !== 1) begin
      bad++; $display("FAIL single_latency got=%0d required=1", last_out_cyc - last_ack_cyc);
    end
  endtask

  task automatic test_shift_coef();
    bit ok;
    cfg_write(1, 3);
    cfg_write(2, -2);
    pend[1].push_back(25'h0000010);
    wait_idle(ok);
    total++;
    if (!ok || last_out() !== {2'd1, 25'h0000080}) begin
      bad++; $display("FAIL shift_left got=%h required=%h", last_out(), {2'd1, 25'h0000080});
    end
    pend[2].push_back(25'h1FFFFF0);
    wait_idle(ok);
    total++;
    if (!ok || last_out() !== {2'd2, 25'h1FFFFFC}) begin
      bad++; $display("FAIL shift_right got=%h required=%h", last_out(), {2'd2, 25'h1FFFFFC});
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit rr_ok;
    bit cont_ok;
    do_reset();
    cfg_write(3, -1);
    cfg_write(1, 2);
    ack_log.delete();
    out_cyc_log.delete();
    for (int i = 0; i < 5; i++)
      for (int c = 0; c < NC; c++) pend[c].push_back(DW'($urandom));
    wait_idle(ok);
    total++;
    if (!ok || ack_log.size() != 20) begin
      bad++; $display("FAIL rr_count got=%0d required=20", ack_log.size());
    end
    rr_ok = 1;
    foreach (ack_log[i]) if (ack_log[i] != i % NC) rr_ok = 0;
    total++;
    if (!rr_ok || ack_log.size() == 0) begin
      bad++; $display("FAIL rr_order got=%0d.. required=0,1,2,3,0..", ack_log.size() ? ack_log[0] : -1);
    end
    cont_ok = (out_cyc_log.size() == 20);
    for (int i = 1; i < out_cyc_log.size(); i++) if (out_cyc_log[i] != out_cyc_log[i-1] + 1) cont_ok = 0;
    total++;
    if (!cont_ok) begin
      bad++; $display("FAIL rr_continuous got=%0d_results required=20_consecutive", out_cyc_log.size());
    end
  endtask

  task automatic test_cfg_same_edge();
    bit ok;
    @(negedge clk);
    pend[0].push_back(25'h0000100);
    @(negedge clk);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = 2'd0;
    bus.cfg_shift = 5'sd1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok || last_out() !== {2'd0, 25'h0000100}) begin
      bad++; $display("FAIL cfg_old got=%h required=%h", last_out(), {2'd0, 25'h0000100});
    end
    pend[0].push_back(25'h0000100);
    wait_idle(ok);
    total++;
    if (!ok || last_out() !== {2'd0, 25'h0000200}) begin
      bad++; $display("FAIL cfg_new got=%h required=%h", last_out(), {2'd0, 25'h0000200});
    end
  endtask

  task automatic test_overflow();
    bit ok;
    cfg_write(3, 4);
    pend[3].push_back(25'h0F00000);
    wait_idle(ok);
    total++;
    if (!ok || last_out() !== {2'd3, 25'h1000000}) begin
      bad++; $display("FAIL ovf_wrap got=%h required=%h", last_out(), {2'd3, 25'h1000000});
    end
    cfg_write(3, 15);
    pend[3].push_back(25'h0000400);
    wait_idle(ok);
    total++;
    if (!ok || last_out() !== {2'd3, 25'h0000000}) begin
      bad++; $display("FAIL ovf_zero got=%h required=%h", last_out(), {2'd3, 25'h0000000});
    end
    cfg_write(3, -16);
    pend[3].push_back(25'h1FFF000);
    wait_idle(ok);
    total++;
    if (!ok || last_out() !== {2'd3, 25'h1FFFFFF}) begin
      bad++; $display("FAIL ovf_signfill got=%h required=%h", last_out(), {2'd3, 25'h1FFFFFF});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    cfg_write(1, 1);
    pend[1].push_back(25'h0000020);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pend[1].size() == 0) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL mid_grant_timeout got=no_ack required=ack"); end
    rst = 1'b1;
    n = out_log.size();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (out_log.size() != n) begin
      bad++; $display("FAIL mid_discard got=%0d_results required=%0d", out_log.size(), n);
    end
    total++;
    if ({bus.data_o_ch, bus.data_o} !== '0) begin
      bad++; $display("FAIL mid_outputs got=%h required=0", {bus.data_o_ch, bus.data_o});
    end
    ack_log.delete();
    pend[3].push_back(25'h0000020);
    pend[1].push_back(25'h0000020);
    wait_idle(ok);
    total++;
    if (!ok || ack_log.size() == 0 || ack_log[0] != 1) begin
      bad++; $display("FAIL mid_ptr got=%0d required=1", ack_log.size() ? ack_log[0] : -1);
    end
    total++;
    if (out_log.size() < n + 1 || out_log[n] !== {2'd1, 25'h0000020}) begin
      bad++; $display("FAIL mid_coef got=%h required=%h",
                      (out_log.size() > n) ? out_log[n] : 'x, {2'd1, 25'h0000020});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift_coef();
    test_back_to_back();
    test_cfg_same_edge();
    test_overflow();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1);
  end
endmodule
